// File: rtl/edge_pkg.sv
// Shared edge-pipeline types: pixel class codes and threshold-stage FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package edge_pkg;

   // Class map encoding consumed by the hysteresis stage
   typedef enum logic [1:0] {
      NONE   = 2'b00,
      WEAK   = 2'b01,
      STRONG = 2'b10
   } pixel_class_t;

   // Threshold stage sequencing
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10,
      DONE  = 2'b11
   } threshold_state_t;

endpackage

// File: rtl/pixel_classifier.sv
// Purpose: unsigned double-threshold classification of one magnitude pixel.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module pixel_classifier
   import edge_pkg::*;
#(
   parameter int PIX_W = 8
) (
   input  logic [PIX_W-1:0] pix,
   input  logic [PIX_W-1:0] high,
   input  logic [PIX_W-1:0] low,
   output pixel_class_t     pix_class
);

   // Strong wins over weak; equality with a threshold counts as reaching it
   always_comb begin
      pix_class = NONE;
      if (pix >= high) begin
         pix_class = STRONG;
      end else if (pix >= low) begin
         pix_class = WEAK;
      end
   end

endmodule

// File: rtl/threshold_stage.sv
// Purpose: stream a whole magnitude frame, classify each pixel, write the 2-bit class map.
// Latency: read issued at cycle t -> write registered at t+RD_LAT+1; done at N+RD_LAT+2 after enable.
// Backpressure: none; source and class map must accept one access per cycle. Build option THRESH_STATS_EN.
module threshold_stage
   import edge_pkg::*;
#(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int PIX_W  = 8,
   parameter int ADDR_W = 12,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              threshold_enable,
   output logic              threshold_done,
   input  logic [PIX_W-1:0]  high_thresh,
   input  logic [PIX_W-1:0]  low_thresh,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [PIX_W-1:0]  rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [1:0]        wr_data
`ifdef THRESH_STATS_EN
   ,
   output logic [ADDR_W:0]   strong_count,
   output logic [ADDR_W:0]   weak_count
`endif
);

   localparam int N  = IMG_W * IMG_H;
   localparam int DW = $clog2(RD_LAT + 2);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
   localparam logic [DW-1:0]     DRAIN_LAST = DW'(RD_LAT);

   threshold_state_t  state;
   logic [ADDR_W-1:0] addr_cnt;
   logic [DW-1:0]     drain_cnt;
   logic [PIX_W-1:0]  high_q;
   logic [PIX_W-1:0]  low_q;
   logic [PIX_W-1:0]  low_min;

   logic              start;
   logic              abort;
   logic              write_fire;

   logic [RD_LAT-1:0] pipe_vld;
   logic [ADDR_W-1:0] pipe_addr [RD_LAT];

   pixel_class_t      pix_class;

   // A weak threshold above the strong one collapses onto the strong one
   assign low_min = (low_thresh < high_thresh) ? low_thresh : high_thresh;

   assign start = (state == IDLE) && threshold_enable;
   assign abort = ((state == RUN) || (state == DRAIN)) && !threshold_enable;

   // Reads are issued straight from the FSM registers, so reset clears them immediately
   assign rd_en          = (state == RUN);
   assign rd_addr        = addr_cnt;
   assign threshold_done = (state == DONE);

   // Sequencing: one read per cycle, then wait for the read pipe to empty
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_cnt  <= '0;
         drain_cnt <= '0;
         high_q    <= '0;
         low_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (threshold_enable) begin
                  high_q   <= high_thresh;
                  low_q    <= low_min;
                  addr_cnt <= '0;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (!threshold_enable) begin
                  state <= IDLE;
               end else if (addr_cnt == LAST_ADDR) begin
                  drain_cnt <= '0;
                  state     <= DRAIN;
               end else begin
                  addr_cnt <= addr_cnt + ADDR_W'(1);
               end
            end
            DRAIN: begin
               if (!threshold_enable) begin
                  state <= IDLE;
               end else if (drain_cnt == DRAIN_LAST) begin
                  state <= DONE;
               end else begin
                  drain_cnt <= drain_cnt + DW'(1);
               end
            end
            DONE: begin
               if (!threshold_enable) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Track each read's address until its data returns; an abort drops everything in flight
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_addr[i] <= '0;
         end
      end else if (abort) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0]  <= rd_en;
         pipe_addr[0] <= rd_addr;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end

   assign write_fire = pipe_vld[RD_LAT-1] && !abort;

   pixel_classifier #(
      .PIX_W (PIX_W)
   ) u_classifier (
      .pix       (rd_data),
      .high      (high_q),
      .low       (low_q),
      .pix_class (pix_class)
   );

   // Register the class map write; address/data only move on a real write
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= 2'b00;
      end else begin
         wr_en <= write_fire;
         if (write_fire) begin
            wr_addr <= pipe_addr[RD_LAT-1];
            wr_data <= pix_class;
         end
      end
   end

`ifdef THRESH_STATS_EN
   localparam int CW = ADDR_W + 1;

   // Per-frame class tallies, counted alongside the write and held after the frame
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         strong_count <= '0;
         weak_count   <= '0;
      end else if (start) begin
         strong_count <= '0;
         weak_count   <= '0;
      end else if (write_fire) begin
         if ((pix_class == STRONG) && (strong_count != '1)) begin
            strong_count <= strong_count + CW'(1);
         end
         if ((pix_class == WEAK) && (weak_count != '1)) begin
            weak_count <= weak_count + CW'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_threshold_stage.sv
// Bench for threshold_stage: RD_LAT=1 and RD_LAT=3 instances share stimulus, each checked
// every cycle against a frame-level timeline model; directed frames pin the model with literals.
// Optional count ports follow THRESH_STATS_EN.
module tb_threshold_stage;

   localparam int IMG_W  = 4;
   localparam int IMG_H  = 4;
   localparam int N      = IMG_W * IMG_H;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              en = 1'b0;
   logic [PIX_W-1:0]  hi_t = '0;
   logic [PIX_W-1:0]  lo_t = '0;

   logic              rd_en1, rd_en3, wr_en1, wr_en3, done1, done3;
   logic [ADDR_W-1:0] rd_addr1, rd_addr3, wr_addr1, wr_addr3;
   logic [PIX_W-1:0]  rd_data1, rd_data3;
   logic [1:0]        wr_data1, wr_data3;
`ifdef THRESH_STATS_EN
   logic [ADDR_W:0]   sc1, wc1, sc3, wc3;
`endif

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   threshold_stage #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(1)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .threshold_enable(en), .threshold_done(done1),
      .high_thresh(hi_t), .low_thresh(lo_t),
      .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
      .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1)
`ifdef THRESH_STATS_EN
      , .strong_count(sc1), .weak_count(wc1)
`endif
   );

   threshold_stage #(
      .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .ADDR_W(ADDR_W), .RD_LAT(3)
   ) u_dut3 (
      .clk(clk), .reset_n(reset_n), .threshold_enable(en), .threshold_done(done3),
      .high_thresh(hi_t), .low_thresh(lo_t),
      .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
      .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3)
`ifdef THRESH_STATS_EN
      , .strong_count(sc3), .weak_count(wc3)
`endif
   );

   // Source frame buffer with 1- and 3-cycle read latency views
   logic [PIX_W-1:0] mem [N];
   logic [PIX_W-1:0] p1;
   logic [PIX_W-1:0] p3 [3];
   always @(posedge clk) begin
      p1    <= rd_en1 ? mem[rd_addr1[3:0]] : 8'hEE;
      p3[0] <= rd_en3 ? mem[rd_addr3[3:0]] : 8'hEE;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign rd_data1 = p1;
   assign rd_data3 = p3[2];

   int checks = 0;
   int errors = 0;

   // Frame-level model per instance: mode 0 idle, 1 running (timeline from start cycle), 2 done
   int         lat [2] = '{1, 3};
   int         md  [2] = '{0, 0};
   int         st  [2] = '{0, 0};
   logic [7:0] mh  [2];
   logic [7:0] ml  [2];
   int         esc [2] = '{0, 0};
   int         ewc [2] = '{0, 0};
   // Observation logs for the literal checks, reset at each model start
   int         nwr      [2] = '{0, 0};
   int         last_wr  [2] = '{-1, -1};
   int         first_wa [2] = '{-1, -1};
   int         done_at  [2] = '{-1, -1};
   logic [1:0] seen [2][N];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic string tag(input int i, input string s);
      return $sformatf("%s_lat%0d", s, lat[i]);
   endfunction

   // 2 strong, 1 weak, 0 none; the weak level never exceeds the strong level
   function automatic int class_of(input int pix, input int h, input int l);
      int lo_eff;
      lo_eff = (l < h) ? l : h;
      if (pix >= h) return 2;
      if (pix >= lo_eff) return 1;
      return 0;
   endfunction

   always @(negedge clk) begin : compare
      int k, j, ecls, o_ra, o_wa, o_wd;
      bit o_rd, o_wr, o_dn, e_rd, e_wr, e_dn;
      if (!reset_n) begin
         md[0] = 0;
         md[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
               o_rd = rd_en1; o_ra = int'(rd_addr1); o_wr = wr_en1;
               o_wa = int'(wr_addr1); o_wd = int'(wr_data1); o_dn = done1;
            end else begin
               o_rd = rd_en3; o_ra = int'(rd_addr3); o_wr = wr_en3;
               o_wa = int'(wr_addr3); o_wd = int'(wr_data3); o_dn = done3;
            end
            k = cyc - st[i];
            j = k - lat[i] - 2;
            e_rd = (md[i] == 1) && (k >= 1) && (k <= N);
            e_wr = (md[i] == 1) && (j >= 0) && (j < N);
            e_dn = (md[i] == 2);
            chk(tag(i, "rd_en"), int'(o_rd), int'(e_rd));
            if (e_rd) chk(tag(i, "rd_addr"), o_ra, k - 1);
            chk(tag(i, "wr_en"), int'(o_wr), int'(e_wr));
            if (e_wr) begin
               ecls = class_of(int'(mem[j]), int'(mh[i]), int'(ml[i]));
               chk(tag(i, "wr_addr"), o_wa, j);
               chk(tag(i, "wr_data"), o_wd, ecls);
               if (ecls == 2) esc[i]++;
               else if (ecls == 1) ewc[i]++;
            end
            chk(tag(i, "done"), int'(o_dn), int'(e_dn));
`ifdef THRESH_STATS_EN
            chk(tag(i, "strong_count"), (i == 0) ? int'(sc1) : int'(sc3), esc[i]);
            chk(tag(i, "weak_count"), (i == 0) ? int'(wc1) : int'(wc3), ewc[i]);
`endif
            if (o_wr) begin
               if (nwr[i] == 0) first_wa[i] = o_wa;
               nwr[i]++;
               last_wr[i] = k;
               if (o_wa < N) seen[i][o_wa] = o_wd[1:0];
            end
            if (o_dn && done_at[i] < 0) done_at[i] = k;
            case (md[i])
               0: if (en) begin
                     md[i] = 1; st[i] = cyc; mh[i] = hi_t; ml[i] = lo_t;
                     esc[i] = 0; ewc[i] = 0; nwr[i] = 0;
                     last_wr[i] = -1; first_wa[i] = -1; done_at[i] = -1;
                     for (int a = 0; a < N; a++) seen[i][a] = 2'b11;
                  end
               1: if (!en) md[i] = 0;
                  else if (k == N + lat[i] + 1) md[i] = 2;
               default: if (!en) md[i] = 0;
            endcase
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      step(1);
      while (done_at[1] < 0 && n < budget) begin
         step(1);
         n++;
      end
      chk("done_timeout", int'(done_at[1] >= 0), 1);
   endtask

   task automatic rst_zero(input string s);
      chk({s, "_rd_en1"}, int'(rd_en1), 0);     chk({s, "_rd_en3"}, int'(rd_en3), 0);
      chk({s, "_rd_addr1"}, int'(rd_addr1), 0); chk({s, "_rd_addr3"}, int'(rd_addr3), 0);
      chk({s, "_wr_en1"}, int'(wr_en1), 0);     chk({s, "_wr_en3"}, int'(wr_en3), 0);
      chk({s, "_wr_addr1"}, int'(wr_addr1), 0); chk({s, "_wr_addr3"}, int'(wr_addr3), 0);
      chk({s, "_wr_data1"}, int'(wr_data1), 0); chk({s, "_wr_data3"}, int'(wr_data3), 0);
      chk({s, "_done1"}, int'(done1), 0);       chk({s, "_done3"}, int'(done3), 0);
`ifdef THRESH_STATS_EN
      chk({s, "_sc3"}, int'(sc3), 0);           chk({s, "_wc3"}, int'(wc3), 0);
`endif
   endtask

   initial begin
      int weak_seen;
      int len;
      for (int a = 0; a < N; a++) mem[a] = 8'(a * 16);

      // Power-on reset
      #2;
      rst_zero("por");
      step(2);
      reset_n = 1'b1;
      step(1);

      // Frame 1: high 128, low 64
      hi_t = 8'd128; lo_t = 8'd64; en = 1'b1;
      wait_done(60);
      chk("f1_done_cycle_lat1", done_at[0], 19);
      chk("f1_done_cycle_lat3", done_at[1], 21);
      chk("f1_writes_lat1", nwr[0], 16);
      chk("f1_writes_lat3", nwr[1], 16);
      chk("f1_class_a3", int'(seen[0][3]), 0);
      chk("f1_class_a4_eq_low", int'(seen[0][4]), 1);
      chk("f1_class_a7", int'(seen[0][7]), 1);
      chk("f1_class_a8_eq_high", int'(seen[0][8]), 2);
      chk("f1_class_a15", int'(seen[1][15]), 2);
`ifdef THRESH_STATS_EN
      chk("f1_strong_count_lat3", int'(sc3), 8);
      chk("f1_weak_count_lat3", int'(wc3), 4);
`endif
      en = 1'b0;
      step(2);

      // Frame 2: low above high collapses weak onto strong
      hi_t = 8'd100; lo_t = 8'd200; en = 1'b1;
      wait_done(60);
      weak_seen = 0;
      for (int a = 0; a < N; a++) if (seen[0][a] == 2'b01) weak_seen++;
      chk("f2_no_weak", weak_seen, 0);
      chk("f2_class_a6", int'(seen[0][6]), 0);
      chk("f2_class_a7", int'(seen[0][7]), 2);
      en = 1'b0;
      step(2);

      // Frame 3: abort at cycle 6, then a clean re-run
      hi_t = 8'd128; lo_t = 8'd64; en = 1'b1;
      step(6);
      en = 1'b0;
      step(12);
      chk("abort_last_wr_le7", int'(last_wr[0] <= 7), 1);
      chk("abort_writes_lat1", nwr[0], 4);
      chk("abort_writes_lat3", nwr[1], 2);
      chk("abort_no_done_lat1", done_at[0], -1);
      chk("abort_no_done_lat3", done_at[1], -1);
      en = 1'b1;
      wait_done(60);
      chk("rerun_writes", nwr[0], 16);
      chk("rerun_first_addr", first_wa[0], 0);
      en = 1'b0;
      step(2);

      // Frame 4: asynchronous reset mid-run, enable kept high to restart
      en = 1'b1;
      step(8);
      reset_n = 1'b0;
      #1;
      rst_zero("mid");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      wait_done(60);
      chk("postrst_writes", nwr[0], 16);
      chk("postrst_first_addr", first_wa[0], 0);
      chk("postrst_first_addr_lat3", first_wa[1], 0);
      en = 1'b0;
      step(2);

      // Random frames: random pixels, thresholds, run lengths; thresholds wiggle mid-run
      for (int r = 0; r < 24; r++) begin
         hi_t = 8'($urandom);
         lo_t = (r % 5 == 0) ? hi_t : 8'($urandom);
         for (int a = 0; a < N; a++) begin
            case ($urandom_range(0, 3))
               0: mem[a] = hi_t;
               1: mem[a] = lo_t;
               default: mem[a] = 8'($urandom);
            endcase
         end
         en = 1'b1;
         len = (r % 3 == 0) ? $urandom_range(2, 20) : $urandom_range(22, 30);
         for (int c = 0; c < len; c++) begin
            step(1);
            hi_t = 8'($urandom);
            lo_t = 8'($urandom);
         end
         en = 1'b0;
         step($urandom_range(1, 3));
      end

      step(3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion, expected finish before 200000");
      $fatal(1);
   end

endmodule
